uart_tx_arbiter: RTL and testbench

//  Shares one uart_tx transmitter among N byte requesters. Round-robin arbitration

---
 rtl/uart_tx_arbiter_pkg.sv | 6 +
 rtl/uart_tx_arbiter_rr_pick.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 82 ++++++++
 tb/tb_uart_tx_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared FSM state encoding and default sizing for the uart transmit arbiter
package uart_tx_arbiter_pkg;
   typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE, HOLD} state_t;
   localparam int N_DEF = 4;
   localparam int HOLD_MAX_DEF = 1024;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_tx_arbiter_rr_pick: combinational round-robin picker, first set request at or after ptr
module uart_tx_arbiter_rr_pick #(
   parameter int N = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [PW-1:0] idx,
   output logic          any
);
   int s;
   assign any = |req;
   always_comb begin
      idx = '0;
      s = 0;
      // walk from farthest to nearest so the nearest hit wins
      for (int k = N - 1; k >= 0; k--) begin
         s = int'(ptr) + k;
         if (s >= N) s = s - N;
         if (req[s[PW-1:0]]) idx = s[PW-1:0];
      end
      onehot = any ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one uart_tx among N byte requesters
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int HOLD_MAX = HOLD_MAX_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req_valid,
   input  logic [8*N-1:0] req_data,
   input  logic [N-1:0]   req_last,
   output logic [N-1:0]   req_ack,
   output logic           tx_start,
   output logic [7:0]     tx_data,
   input  logic           tx_ready,
   output logic [N-1:0]   grant,
   output logic           busy
);
   localparam int PW = $clog2(N);
   localparam int HW = $clog2(HOLD_MAX);
   state_t state, nxt;
   logic [PW-1:0] win, rr_ptr, pick_idx, win_inc;
   logic [N-1:0] pick_oh;
   logic pick_any, last_q, own_valid, hold_end, rel;
   logic [HW-1:0] hold_cnt;
   logic [7:0] data_q, win_data;

   uart_tx_arbiter_rr_pick #(.N(N)) u_pick (
      .req(req_valid), .ptr(rr_ptr), .onehot(pick_oh), .idx(pick_idx), .any(pick_any)
   );

   assign own_valid = req_valid[win];
   assign win_data = req_data[win*8 +: 8];
   assign win_inc = (win == PW'(N-1)) ? '0 : win + 1'b1;
   assign hold_end = hold_cnt == HW'(HOLD_MAX-1);
   assign tx_start = state == SEND;
   assign req_ack = tx_start ? grant : '0;
   // data is presented with the start pulse and then held from the register
   assign tx_data = tx_start ? win_data : data_q;
   assign busy = state != IDLE;
   assign rel = (state == WAIT_DONE || state == HOLD) && nxt == IDLE;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:      if (pick_any && tx_ready) nxt = SEND;
         SEND:      nxt = WAIT_BUSY;
         WAIT_BUSY: if (!tx_ready) nxt = WAIT_DONE;
         WAIT_DONE: if (tx_ready) nxt = last_q ? IDLE : own_valid ? SEND : HOLD;
         HOLD:      nxt = own_valid ? SEND : hold_end ? IDLE : HOLD;
         default:   nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         win <= '0;
         rr_ptr <= '0;
         last_q <= 1'b0;
         hold_cnt <= '0;
         data_q <= 8'h00;
      end else begin
         state <= nxt;
         if (state == IDLE && nxt == SEND) begin
            grant <= pick_oh;
            win <= pick_idx;
         end
         if (rel) begin
            grant <= '0;
            rr_ptr <= win_inc;
         end
         if (tx_start) begin
            data_q <= win_data;
            last_q <= req_last[win];
         end
         hold_cnt <= state == HOLD ? hold_cnt + 1'b1 : '0;
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table vectors, corner sequences and randomized packets against a queue-level model
module tb_uart_tx_arbiter;
   localparam int N = 4;
   localparam int HM = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0] req_valid = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0] req_last = '0;
   logic [N-1:0] req_ack, grant;
   logic tx_start, busy;
   logic [7:0] tx_data;
   logic tx_ready = 1'b1;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N(N), .HOLD_MAX(HM)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ack(req_ack), .tx_start(tx_start), .tx_data(tx_data), .tx_ready(tx_ready),
      .grant(grant), .busy(busy)
   );

   typedef struct packed {logic [7:0] d; logic l;} byte_t;
   typedef struct packed {logic [1:0] w; logic [7:0] d;} rec_t;
   typedef struct {int pre; logic [N-1:0] valid; logic [N-1:0] exp;} vec_t;
   byte_t q[N][$];
   rec_t line[$], expq[$];
   int checks = 0, failures = 0;
   int ack_cnt[N];
   int busy_cnt = 0;
   logic auto_drv = 1'b0;
   logic [N-1:0] pend = '0;
   logic [7:0] prev_data = 8'h00;
   logic prev_ready = 1'b1, rst_q = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // uart_tx stand-in: ready drops on start, returns after a random frame length
   always @(posedge clk) begin
      rst_q <= rst;
      if (tx_start) begin
         for (int i = 0; i < N; i++) if (grant[i]) line.push_back({2'(i), tx_data});
         tx_ready <= 1'b0;
         busy_cnt <= $urandom_range(10, 2);
      end else if (!tx_ready) begin
         if (busy_cnt == 0) tx_ready <= 1'b1;
         else busy_cnt <= busy_cnt - 1;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) ack_cnt[i] += int'(req_ack[i]);
      chk("onehot_grant", 32'($onehot0(grant)), 1);
      chk("ack_popcount", 32'($countones(req_ack) <= 1), 1);
      chk("start_ready", 32'(!tx_start || tx_ready), 1);
      if (!rst_q && !prev_ready && !tx_ready) chk("data_stable", 32'(tx_data), 32'(prev_data));
      prev_data = tx_data;
      prev_ready = tx_ready;
   end

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i] = q[i].size() != 0;
         req_data[8*i +: 8] = q[i].size() != 0 ? q[i][0].d : 8'h00;
         req_last[i] = q[i].size() != 0 ? q[i][0].l : 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (auto_drv) begin
         for (int i = 0; i < N; i++) if (pend[i]) void'(q[i].pop_front());
         drive();
      end
      pend = req_ack;
   endtask

   task automatic do_reset();
      req_valid = '0;
      req_data = '0;
      req_last = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < N; i++) ack_cnt[i] = 0;
      line.delete();
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((busy || !tx_ready) && n < 200) begin tick(); n++; end
      chk(name, 32'(n < 200), 1);
   endtask

   task automatic wait_ack(input string name, input int r);
      int n = 0;
      while (!req_ack[r] && n < 60) begin tick(); n++; end
      chk(name, 32'(req_ack[r]), 1);
   endtask

   task automatic send_one(input int r, input logic [7:0] d);
      req_valid[r] = 1'b1;
      req_data[8*r +: 8] = d;
      req_last[r] = 1'b1;
      wait_ack("send_ack", r);
      req_valid[r] = 1'b0;
      wait_idle("send_idle");
   endtask

   function automatic int pending();
      int s = 0;
      for (int i = 0; i < N; i++) s += q[i].size();
      return s;
   endfunction

   // reference: whole packets served in rotating order from the pointer
   task automatic build_exp();
      byte_t m[N][$];
      byte_t b;
      int ptr = 0, w;
      for (int i = 0; i < N; i++) m[i] = q[i];
      expq.delete();
      while (1) begin
         w = -1;
         for (int k = 0; k < N; k++) if (w < 0 && m[(ptr + k) % N].size() != 0) w = (ptr + k) % N;
         if (w < 0) break;
         do begin
            b = m[w].pop_front();
            expq.push_back({2'(w), b.d});
         end while (!b.l);
         ptr = (w + 1) % N;
      end
   endtask

   task automatic run_auto(input string name);
      int n = 0;
      build_exp();
      line.delete();
      pend = '0;
      auto_drv = 1'b1;
      drive();
      while ((pending() != 0 || busy || !tx_ready) && n < 5000) begin tick(); n++; end
      auto_drv = 1'b0;
      chk({name, "_done"}, 32'(n < 5000), 1);
      chk({name, "_len"}, 32'(line.size()), 32'(expq.size()));
      for (int i = 0; i < line.size() && i < expq.size(); i++)
         chk({name, "_byte"}, 32'(line[i]), 32'(expq[i]));
   endtask

   task automatic fill_random();
      int np, nb;
      for (int i = 0; i < N; i++) begin
         q[i].delete();
         np = $urandom_range(2, 0);
         for (int p = 0; p < np; p++) begin
            nb = $urandom_range(3, 1);
            for (int b = 0; b < nb; b++) q[i].push_back({8'($urandom), b == nb - 1});
         end
      end
   endtask

   initial begin
      vec_t tbl[8];
      int n;
      tbl[0] = '{0, 4'b0101, 4'b0100};
      tbl[1] = '{1, 4'b0101, 4'b0100};
      tbl[2] = '{2, 4'b0101, 4'b0001};
      tbl[3] = '{3, 4'b1111, 4'b0001};
      tbl[4] = '{3, 4'b1000, 4'b1000};
      tbl[5] = '{0, 4'b0011, 4'b0010};
      tbl[6] = '{2, 4'b0110, 4'b0010};
      tbl[7] = '{1, 4'b1001, 4'b1000};

      do_reset();
      chk("rst_grant", 32'(grant), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_start", 32'(tx_start), 0);
      chk("rst_ack", 32'(req_ack), 0);
      chk("rst_data", 32'(tx_data), 0);

      req_valid[0] = 1'b1;
      req_data[7:0] = 8'h41;
      req_last[0] = 1'b1;
      chk("single_ack_early", 32'(req_ack), 0);
      tick();
      chk("single_ack", 32'(req_ack), 32'h1);
      chk("single_grant", 32'(grant), 32'h1);
      req_valid[0] = 1'b0;
      wait_idle("single_idle");
      chk("single_line", 32'(line.size() == 1 ? line[0] : '1), 32'({2'd0, 8'h41}));
      chk("single_release", 32'(grant), 0);
      chk("single_ptr", 32'(dut.rr_ptr), 1);
      chk("single_ackcnt", 32'(ack_cnt[0]), 1);

      for (int v = 0; v < 8; v++) begin
         do_reset();
         send_one(tbl[v].pre, 8'h30);
         req_data = 32'h44434241;
         req_last = '1;
         req_valid = tbl[v].valid;
         n = 0;
         while (grant == '0 && n < 20) begin tick(); n++; end
         chk("tbl_grant", 32'(grant), 32'(tbl[v].exp));
         chk("tbl_ack", 32'(req_ack), 32'(tbl[v].exp));
         req_valid = '0;
         wait_idle("tbl_idle");
      end

      do_reset();
      q[0] = '{{8'h61, 1'b1}, {8'h63, 1'b1}};
      q[1] = '{};
      q[2] = '{{8'h62, 1'b1}};
      q[3] = '{};
      run_auto("contention");

      do_reset();
      q[0] = '{};
      q[1] = '{{8'h48, 1'b0}, {8'h4f, 1'b0}, {8'h4c, 1'b1}};
      q[2] = '{};
      q[3] = '{{8'h51, 1'b1}};
      run_auto("lock");

      do_reset();
      req_valid = 4'b0110;
      req_data = {8'h00, 8'h5a, 8'h58, 8'h00};
      req_last = 4'b0100;
      wait_ack("stall_ack1", 1);
      req_valid[1] = 1'b0;
      n = 0;
      while (tx_ready && n < 20) begin tick(); n++; end
      n = 0;
      while (!tx_ready && n < 40) begin tick(); n++; end
      n = 0;
      while (grant != '0 && n < 100) begin tick(); n++; end
      chk("stall_hold_len", 32'(n), HM + 1);
      wait_ack("stall_ack2", 2);
      req_valid = '0;
      wait_idle("stall_idle");
      chk("stall_len", 32'(line.size()), 2);
      chk("stall_last", 32'(line.size() == 2 ? line[1] : '1), 32'({2'd2, 8'h5a}));

      do_reset();
      req_valid[0] = 1'b1;
      req_data[7:0] = 8'h52;
      req_last[0] = 1'b1;
      wait_ack("mid_ack0", 0);
      req_valid[0] = 1'b0;
      n = 0;
      while (tx_ready && n < 20) begin tick(); n++; end
      tick();
      rst = 1'b1;
      tick();
      chk("mid_busy", 32'(busy), 0);
      chk("mid_grant", 32'(grant), 0);
      chk("mid_start", 32'(tx_start), 0);
      chk("mid_ack", 32'(req_ack), 0);
      rst = 1'b0;
      req_valid[3] = 1'b1;
      req_data[31:24] = 8'h53;
      req_last[3] = 1'b1;
      wait_ack("mid_ack3", 3);
      req_valid[3] = 1'b0;
      wait_idle("mid_idle");
      chk("mid_ackcnt0", 32'(ack_cnt[0]), 1);
      chk("mid_ackcnt3", 32'(ack_cnt[3]), 1);
      chk("mid_line", 32'(line.size() == 2 ? line[1] : '1), 32'({2'd3, 8'h53}));

      for (int r = 0; r < 6; r++) begin
         do_reset();
         fill_random();
         run_auto("random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
